// File: rtl/hsv_to_rgb_encoder_if.sv
// rtl/hsv_to_rgb_encoder_if.sv - pixel handshake bundle for hsv_to_rgb_encoder
//
// Carries both sides of the encoder's valid/ready streams:
//   i_hue[10:0], i_sat[7:0], i_val[7:0], i_valid : HSV pixel into the encoder
//   o_ready                                      : encoder accepts the input pixel
//   o_data[15:0], o_valid                        : RGB565 pixel out of the encoder
//   i_ready                                      : downstream accepts the output pixel
// master : the pixel source / sink surrounding the encoder
// slave  : the encoder itself
interface hsv_to_rgb_encoder_if;
    logic [10:0] i_hue;
    logic [7:0]  i_sat;
    logic [7:0]  i_val;
    logic        i_valid;
    logic        o_ready;
    logic [15:0] o_data;
    logic        o_valid;
    logic        i_ready;

    modport master (
        output i_hue, i_sat, i_val, i_valid, i_ready,
        input  o_ready, o_data, o_valid
    );

    modport slave (
        input  i_hue, i_sat, i_val, i_valid, i_ready,
        output o_ready, o_data, o_valid
    );
endinterface

// File: rtl/hsv_to_rgb_encoder.sv
// rtl/hsv_to_rgb_encoder.sv - 3-stage HSV to RGB565 pixel encoder
//
// Ports:
//   i_clk  : sole clock, all state on the rising edge
//   i_rstn : asynchronous active-low reset
//   bus    : hsv_to_rgb_encoder_if.slave (HSV in, RGB565 out, valid/ready both sides)
//
// Optional build macro HSV_ENC_HUE_CLAMP_EN:
//   defined   : hue codes >= 1536 clamp to 1535
//   undefined : hue codes >= 1536 wrap to hue - 1536
//
// Pipeline: stage 1 normalises hue/saturation, stage 2 forms p/q/t,
// stage 3 selects R/G/B by sector and packs RGB565. All stages share one
// enable so a stalled output freezes the whole pipe.
module hsv_to_rgb_encoder (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    hsv_to_rgb_encoder_if.slave  bus
);

    localparam logic [10:0] HUE_LIMIT = 11'd1536;

    // ------------------------------------------------------------------
    // Global pipeline enable
    // ------------------------------------------------------------------
    logic        en;
    logic        out_valid;
    logic [15:0] out_data;

    // The pipe may advance whenever the output slot is empty or being drained.
    assign en          = !out_valid || bus.i_ready;
    assign bus.o_ready = en;
    assign bus.o_valid = out_valid;
    assign bus.o_data  = out_data;

    // ------------------------------------------------------------------
    // Stage 1: hue range handling, sector/fraction split, saturation scale
    // ------------------------------------------------------------------
    logic [10:0] hue_adj;
    logic [8:0]  sat_adj;

    always_comb begin
        hue_adj = bus.i_hue;
        if (bus.i_hue >= HUE_LIMIT) begin
`ifdef HSV_ENC_HUE_CLAMP_EN
            hue_adj = HUE_LIMIT - 11'd1;
`else
            hue_adj = bus.i_hue - HUE_LIMIT;
`endif
        end
    end

    // Stretch 0..255 onto 0..256 so full saturation yields exactly p = 0.
    assign sat_adj = {1'b0, bus.i_sat} + {8'd0, bus.i_sat[7]};

    logic       s1_valid;
    logic [2:0] s1_sector;
    logic [7:0] s1_frac;
    logic [8:0] s1_sat;
    logic [7:0] s1_val;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            s1_valid  <= 1'b0;
            s1_sector <= 3'd0;
            s1_frac   <= 8'd0;
            s1_sat    <= 9'd0;
            s1_val    <= 8'd0;
        end else if (en) begin
            s1_valid  <= bus.i_valid;
            s1_sector <= hue_adj[10:8];
            s1_frac   <= hue_adj[7:0];
            s1_sat    <= sat_adj;
            s1_val    <= bus.i_val;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: p = V(1-s), q = V(1-s*f), t = V(1-s*(1-f))
    // ------------------------------------------------------------------
    // V*s' <= 255*256 fits 16 bits; V*s'*256 <= 0xFF0000 fits 24 bits.
    logic [15:0] prod_vs;
    logic [23:0] prod_vsf;
    logic [23:0] prod_vsg;
    logic [8:0]  frac_inv;
    logic [7:0]  p_calc;
    logic [7:0]  q_calc;
    logic [7:0]  t_calc;

    assign frac_inv = 9'd256 - {1'b0, s1_frac};
    assign prod_vs  = {8'd0, s1_val} * {7'd0, s1_sat};
    assign prod_vsf = {8'd0, prod_vs} * {16'd0, s1_frac};
    assign prod_vsg = {8'd0, prod_vs} * {15'd0, frac_inv};

    // Each subtrahend is <= V, so the 8-bit differences never underflow.
    assign p_calc = s1_val - 8'(prod_vs  >> 8);
    assign q_calc = s1_val - 8'(prod_vsf >> 16);
    assign t_calc = s1_val - 8'(prod_vsg >> 16);

    logic       s2_valid;
    logic [2:0] s2_sector;
    logic [7:0] s2_val;
    logic [7:0] s2_p;
    logic [7:0] s2_q;
    logic [7:0] s2_t;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            s2_valid  <= 1'b0;
            s2_sector <= 3'd0;
            s2_val    <= 8'd0;
            s2_p      <= 8'd0;
            s2_q      <= 8'd0;
            s2_t      <= 8'd0;
        end else if (en) begin
            s2_valid  <= s1_valid;
            s2_sector <= s1_sector;
            s2_val    <= s1_val;
            s2_p      <= p_calc;
            s2_q      <= q_calc;
            s2_t      <= t_calc;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: sector select and RGB565 packing (truncating)
    // ------------------------------------------------------------------
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;
    logic [15:0] packed_rgb;

    always_comb begin
        red   = s2_val;
        green = s2_t;
        blue  = s2_p;
        case (s2_sector)
            3'd0: begin red = s2_val; green = s2_t;   blue = s2_p;   end
            3'd1: begin red = s2_q;   green = s2_val; blue = s2_p;   end
            3'd2: begin red = s2_p;   green = s2_val; blue = s2_t;   end
            3'd3: begin red = s2_p;   green = s2_q;   blue = s2_val; end
            3'd4: begin red = s2_t;   green = s2_p;   blue = s2_val; end
            3'd5: begin red = s2_val; green = s2_p;   blue = s2_q;   end
            // Sectors 6/7 cannot occur after hue range handling.
            default: begin red = s2_val; green = s2_t; blue = s2_p; end
        endcase
    end

    assign packed_rgb = {5'(red >> 3), 6'(green >> 2), 5'(blue >> 3)};

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            out_valid <= 1'b0;
            out_data  <= 16'd0;
        end else if (en) begin
            out_valid <= s2_valid;
            // Bubbles leave a zero word so o_data never shows stale pixels.
            out_data  <= s2_valid ? packed_rgb : 16'd0;
        end
    end

endmodule

// File: tb/tb_hsv_to_rgb_encoder.sv
// tb/tb_hsv_to_rgb_encoder.sv - self-checking bench for hsv_to_rgb_encoder
module tb_hsv_to_rgb_encoder;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    hsv_to_rgb_encoder_if bus ();

    hsv_to_rgb_encoder dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
    );

    int tests = 0;
    int fails = 0;
    int out_count = 0;
    logic [15:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // HSV -> RGB565 from the colour-wheel definition, using plain integer math.
    function automatic logic [15:0] model(input int hue, input int sat, input int val);
        int h, s, sec, f, p, q, t, r, g, b, word;
        if (hue >= 1536) begin
`ifdef HSV_ENC_HUE_CLAMP_EN
            h = 1535;
`else
            h = hue - 1536;
`endif
        end else begin
            h = hue;
        end
        s   = sat + ((sat >= 128) ? 1 : 0);
        sec = h / 256;
        f   = h % 256;
        p   = val - (val * s) / 256;
        q   = val - (val * s * f) / 65536;
        t   = val - (val * s * (256 - f)) / 65536;
        case (sec)
            0: begin r = val; g = t;   b = p;   end
            1: begin r = q;   g = val; b = p;   end
            2: begin r = p;   g = val; b = t;   end
            3: begin r = p;   g = q;   b = val; end
            4: begin r = t;   g = p;   b = val; end
            default: begin r = val; g = p; b = q; end
        endcase
        word = ((r / 8) * 2048) + ((g / 4) * 32) + (b / 8);
        return 16'(word);
    endfunction

    // Compare process: reset state, o_ready rule, stall hold, output order/data.
    initial begin
        logic        prev_stall;
        logic [15:0] prev_data;
        prev_stall = 1'b0;
        prev_data  = 16'd0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                check("reset_o_valid", {31'd0, bus.o_valid}, 32'd0);
                check("reset_o_data",  {16'd0, bus.o_data},  32'd0);
                check("reset_o_ready", {31'd0, bus.o_ready}, 32'd1);
                exp_q.delete();
                prev_stall = 1'b0;
            end else begin
                check("o_ready_rule", {31'd0, bus.o_ready}, {31'd0, (!bus.o_valid || bus.i_ready)});
                if (prev_stall) begin
                    check("stall_hold_valid", {31'd0, bus.o_valid}, 32'd1);
                    check("stall_hold_data",  {16'd0, bus.o_data},  {16'd0, prev_data});
                end
                if (bus.o_valid && bus.i_ready) begin
                    out_count++;
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL spurious_output: got 0x%0h, expected no output at %0t", bus.o_data, $time);
                    end else begin
                        check("data_vs_model", {16'd0, bus.o_data}, {16'd0, exp_q.pop_front()});
                    end
                end
                if (bus.i_valid && bus.o_ready)
                    exp_q.push_back(model(int'(bus.i_hue), int'(bus.i_sat), int'(bus.i_val)));
                prev_stall = bus.o_valid && !bus.i_ready;
                prev_data  = bus.o_data;
            end
        end
    end

    // Present one pixel, then require it exactly 3 cycles after acceptance.
    task automatic send_lat(input string name, input int hue, input int sat, input int val,
                            input logic [15:0] exp);
        int cyc;
        @(posedge clk); #1;
        bus.i_hue   = 11'(hue);
        bus.i_sat   = 8'(sat);
        bus.i_val   = 8'(val);
        bus.i_valid = 1'b1;
        check({name, "_accept"}, {31'd0, bus.o_ready}, 32'd1);
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        cyc = 1;
        while (!bus.o_valid && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({name, "_latency"}, 32'(cyc), 32'd3);
        check({name, "_data"}, {16'd0, bus.o_data}, {16'd0, exp});
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [15:0] clamp_exp;
    logic [10:0] bp_hue [5] = '{11'd0, 11'd512, 11'd1024, 11'd256, 11'd1300};
    logic [7:0]  bp_sat [5] = '{8'd255, 8'd255, 8'd200, 8'd255, 8'd90};
    logic [7:0]  bp_val [5] = '{8'd255, 8'd255, 8'd180, 8'd255, 8'd77};

    initial begin
        int idx;
        int base;
        bus.i_hue   = 11'd0;
        bus.i_sat   = 8'd0;
        bus.i_val   = 8'd0;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;

`ifdef HSV_ENC_HUE_CLAMP_EN
        clamp_exp = 16'hF800;
`else
        clamp_exp = 16'hFFE0;
`endif

        // Pin the model itself to hand-computed values.
        check("model_pin_red",   {16'd0, model(0, 255, 255)},    32'h0000F800);
        check("model_pin_gray",  {16'd0, model(700, 0, 128)},    32'h00008410);
        check("model_pin_s1",    {16'd0, model(256, 255, 255)},  32'h0000FFE0);
        check("model_pin_range", {16'd0, model(1800, 255, 255)}, {16'd0, clamp_exp});

        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rstn = 1'b1;
        #1;
        check("post_reset_o_ready", {31'd0, bus.o_ready}, 32'd1);

        // Directed colours with literal expectations.
        send_lat("red",      0,    255, 255, 16'hF800);
        send_lat("green",    512,  255, 255, 16'h07E0);
        send_lat("blue",     1024, 255, 255, 16'h001F);
        send_lat("gray128",  700,  0,   128, 16'h8410);
        send_lat("black",    300,  0,   0,   16'h0000);
        send_lat("gray200",  1535, 0,   200, 16'hCE59);
        send_lat("yellow",   256,  255, 255, 16'hFFE0);
        send_lat("hue1535",  1535, 255, 255, 16'hF800);
        send_lat("hue1800",  1800, 255, 255, clamp_exp);

        // Backpressure: 5 pixels streaming, i_ready low for cycles 4..7.
        base = out_count;
        idx  = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            bus.i_ready = !(k >= 4 && k <= 7);
            if (idx < 5) begin
                bus.i_hue   = bp_hue[idx];
                bus.i_sat   = bp_sat[idx];
                bus.i_val   = bp_val[idx];
                bus.i_valid = 1'b1;
            end else begin
                bus.i_valid = 1'b0;
            end
            @(negedge clk);
            if (k >= 4 && k <= 7) begin
                check("bp_o_ready_stall", {31'd0, bus.o_ready}, 32'd0);
                check("bp_o_valid_stall", {31'd0, bus.o_valid}, 32'd1);
            end
            if (bus.i_valid && bus.o_ready) idx++;
        end
        bus.i_ready = 1'b1;
        check("bp_all_accepted",  32'(idx), 32'd5);
        check("bp_all_delivered", 32'(out_count - base), 32'd5);
        check("bp_queue_empty",   32'(exp_q.size()), 32'd0);

        // Reset with 3 pixels in flight.
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            bus.i_hue   = 11'(200 * k + 100);
            bus.i_sat   = 8'd180;
            bus.i_val   = 8'd220;
            bus.i_valid = 1'b1;
        end
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        check("midrst_pre_o_valid", {31'd0, bus.o_valid}, 32'd1);
        rstn = 1'b0;
        #1;
        check("midrst_async_o_valid", {31'd0, bus.o_valid}, 32'd0);
        check("midrst_async_o_data",  {16'd0, bus.o_data},  32'd0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("midrst_no_stale", {31'd0, bus.o_valid}, 32'd0);
        end
        send_lat("midrst_red", 0, 255, 255, 16'hF800);

        // Throughput: 64 back-to-back random pixels, one output per clock.
        base = out_count;
        for (int k = 0; k < 70; k++) begin
            @(posedge clk); #1;
            if (k < 64) begin
                bus.i_hue   = 11'($urandom_range(0, 2047));
                bus.i_sat   = 8'($urandom_range(0, 255));
                bus.i_val   = 8'($urandom_range(0, 255));
                bus.i_valid = 1'b1;
            end else begin
                bus.i_valid = 1'b0;
            end
            @(negedge clk);
            if (k < 64)
                check("tput_o_ready", {31'd0, bus.o_ready}, 32'd1);
            if (k >= 3 && k <= 66)
                check("tput_o_valid", {31'd0, bus.o_valid}, 32'd1);
        end
        check("tput_delivered",   32'(out_count - base), 32'd64);
        check("tput_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
